// File: rtl/sad_block_search.sv
// rtl/sad_block_search.sv - streaming block SAD engine with per-window minimum tracker
module sad_block_search #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int ROWS  = 4,
    parameter int CANDS = 16,
    localparam int SAD_W = WIDTH + $clog2(LANES * ROWS),
    localparam int IDX_W = (CANDS > 1) ? $clog2(CANDS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     in_valid_i,
    input  logic [LANES*WIDTH-1:0]   ori_i,
    input  logic [LANES*WIDTH-1:0]   can_i,
    output logic                     sad_valid_o,
    output logic [SAD_W-1:0]         sad_out_o,
    output logic [IDX_W-1:0]         cand_idx_o,
    output logic                     best_valid_o,
    output logic [SAD_W-1:0]         best_sad_o,
    output logic [IDX_W-1:0]         best_idx_o
);

    localparam int LS_W   = WIDTH + $clog2(LANES);
    localparam int BEAT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(ROWS - 1);
    localparam logic [IDX_W-1:0]  CAND_LAST = IDX_W'(CANDS - 1);

    // Stage 1: input capture
    logic                   v1_q;
    logic [LANES*WIDTH-1:0] ori_q, ori_d;
    logic [LANES*WIDTH-1:0] can_q, can_d;

    // Stage 2: lane differences and lane sum
    logic                   v2_q;
    logic [WIDTH-1:0]       lane_diff [LANES];
    logic [LS_W-1:0]        lane_sum_q, lane_sum_d;

    // Stage 3: block accumulation and candidate numbering
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [SAD_W-1:0]       acc_q, acc_d;
    logic [SAD_W-1:0]       sad_out_q, sad_out_d;
    logic                   sad_valid_q, sad_valid_d;
    logic [IDX_W-1:0]       cand_idx_q, cand_idx_d;
    logic [IDX_W-1:0]       cand_cnt_q, cand_cnt_d;

    // Minimum tracker
    logic [SAD_W-1:0]       min_q, min_d;
    logic [IDX_W-1:0]       min_idx_q, min_idx_d;
    logic [SAD_W-1:0]       cur_min;
    logic [IDX_W-1:0]       cur_idx;
    logic                   best_valid_q, best_valid_d;
    logic [SAD_W-1:0]       best_sad_q, best_sad_d;
    logic [IDX_W-1:0]       best_idx_q, best_idx_d;

    always_comb begin
        ori_d = ori_q;
        can_d = can_q;
        if (in_valid_i) begin
            ori_d = ori_i;
            can_d = can_i;
        end
    end

    // Compare-then-subtract keeps each lane difference exact whichever pixel is larger
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] a, b;
        assign a = ori_q[i*WIDTH +: WIDTH];
        assign b = can_q[i*WIDTH +: WIDTH];
        assign lane_diff[i] = (a >= b) ? (a - b) : (b - a);
    end

    always_comb begin
        lane_sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum_d = lane_sum_d + LS_W'(lane_diff[i]);
        end
    end

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        acc_d       = acc_q;
        sad_out_d   = sad_out_q;
        sad_valid_d = 1'b0;
        cand_idx_d  = cand_idx_q;
        cand_cnt_d  = cand_cnt_q;
        if (v2_q) begin
            if (beat_cnt_q == BEAT_LAST) begin
                sad_out_d   = acc_q + SAD_W'(lane_sum_q);
                sad_valid_d = 1'b1;
                cand_idx_d  = cand_cnt_q;
                cand_cnt_d  = (cand_cnt_q == CAND_LAST) ? '0 : cand_cnt_q + 1'b1;
                acc_d       = '0;
                beat_cnt_d  = '0;
            end else begin
                acc_d      = acc_q + SAD_W'(lane_sum_q);
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    // Strict less-than so the earliest candidate wins a tie
    always_comb begin
        cur_min = min_q;
        cur_idx = min_idx_q;
        if (sad_out_q < min_q) begin
            cur_min = sad_out_q;
            cur_idx = cand_idx_q;
        end
    end

    always_comb begin
        min_d        = min_q;
        min_idx_d    = min_idx_q;
        best_valid_d = 1'b0;
        best_sad_d   = best_sad_q;
        best_idx_d   = best_idx_q;
        if (sad_valid_q) begin
            if (cand_idx_q == CAND_LAST) begin
                best_valid_d = 1'b1;
                best_sad_d   = cur_min;
                best_idx_d   = cur_idx;
                min_d        = '1;
                min_idx_d    = '0;
            end else begin
                min_d     = cur_min;
                min_idx_d = cur_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            v1_q         <= 1'b0;
            ori_q        <= '0;
            can_q        <= '0;
            v2_q         <= 1'b0;
            lane_sum_q   <= '0;
            beat_cnt_q   <= '0;
            acc_q        <= '0;
            sad_out_q    <= '0;
            sad_valid_q  <= 1'b0;
            cand_idx_q   <= '0;
            cand_cnt_q   <= '0;
            min_q        <= '1;
            min_idx_q    <= '0;
            best_valid_q <= 1'b0;
            best_sad_q   <= '0;
            best_idx_q   <= '0;
        end else begin
            v1_q         <= in_valid_i;
            ori_q        <= ori_d;
            can_q        <= can_d;
            v2_q         <= v1_q;
            lane_sum_q   <= lane_sum_d;
            beat_cnt_q   <= beat_cnt_d;
            acc_q        <= acc_d;
            sad_out_q    <= sad_out_d;
            sad_valid_q  <= sad_valid_d;
            cand_idx_q   <= cand_idx_d;
            cand_cnt_q   <= cand_cnt_d;
            min_q        <= min_d;
            min_idx_q    <= min_idx_d;
            best_valid_q <= best_valid_d;
            best_sad_q   <= best_sad_d;
            best_idx_q   <= best_idx_d;
        end
    end

    assign sad_valid_o  = sad_valid_q;
    assign sad_out_o    = sad_out_q;
    assign cand_idx_o   = cand_idx_q;
    assign best_valid_o = best_valid_q;
    assign best_sad_o   = best_sad_q;
    assign best_idx_o   = best_idx_q;

endmodule

// File: tb/tb_sad_block_search.sv
// tb/tb_sad_block_search.sv - scoreboard bench for sad_block_search (4 lanes, 4 rows, 4 candidates)
module tb_sad_block_search;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int ROWS  = 4;
    localparam int CANDS = 4;
    localparam int SAD_W = 12;
    localparam int IDX_W = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear_i = 1'b0;
    logic               in_valid_i = 1'b0;
    logic [31:0]        ori_i = '0;
    logic [31:0]        can_i = '0;
    logic               sad_valid_o;
    logic [SAD_W-1:0]   sad_out_o;
    logic [IDX_W-1:0]   cand_idx_o;
    logic               best_valid_o;
    logic [SAD_W-1:0]   best_sad_o;
    logic [IDX_W-1:0]   best_idx_o;

    sad_block_search #(.WIDTH(WIDTH), .LANES(LANES), .ROWS(ROWS), .CANDS(CANDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear_i),
        .in_valid_i   (in_valid_i),
        .ori_i        (ori_i),
        .can_i        (can_i),
        .sad_valid_o  (sad_valid_o),
        .sad_out_o    (sad_out_o),
        .cand_idx_o   (cand_idx_o),
        .best_valid_o (best_valid_o),
        .best_sad_o   (best_sad_o),
        .best_idx_o   (best_idx_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sad;
        int idx;
        int cycle;
    } exp_t;

    exp_t sad_q[$];
    exp_t best_q[$];
    exp_t es, eb;
    int vecs = 0;
    int errs = 0;
    int m_cand, m_min, m_idx;
    logic [31:0] blk_o [4];
    logic [31:0] blk_c [4];

    function automatic int beat_sad(input logic [31:0] o, input logic [31:0] c);
        int s = 0;
        for (int l = 0; l < LANES; l++) begin
            int a = int'(o[l*8 +: 8]);
            int b = int'(c[l*8 +: 8]);
            s += (a > b) ? a - b : b - a;
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cand = 0;
        m_min  = 1 << SAD_W;
        m_idx  = 0;
    endtask

    task automatic model_block(input int sad, input int pulse_cyc);
        exp_t e;
        e.sad = sad; e.idx = m_cand; e.cycle = pulse_cyc;
        sad_q.push_back(e);
        if (sad < m_min) begin
            m_min = sad;
            m_idx = m_cand;
        end
        if (m_cand == CANDS - 1) begin
            e.sad = m_min; e.idx = m_idx; e.cycle = pulse_cyc + 1;
            best_q.push_back(e);
            m_cand = 0;
            m_min  = 1 << SAD_W;
            m_idx  = 0;
        end else begin
            m_cand++;
        end
    endtask

    task automatic set_uniform(input int o, input int c);
        for (int b = 0; b < ROWS; b++) begin
            blk_o[b] = {4{o[7:0]}};
            blk_c[b] = {4{c[7:0]}};
        end
    endtask

    // Spreads a target SAD over the 16 pixel slots, alternating which side is larger
    task automatic set_block_sad(input int s);
        int rem = s;
        for (int b = 0; b < ROWS; b++) begin
            blk_o[b] = '0;
            blk_c[b] = '0;
        end
        for (int j = 0; j < LANES * ROWS; j++) begin
            int d = (rem > 255) ? 255 : rem;
            rem -= d;
            if (j % 2 == 0) blk_c[j / LANES][(j % LANES)*8 +: 8] = d[7:0];
            else            blk_o[j / LANES][(j % LANES)*8 +: 8] = d[7:0];
        end
    endtask

    task automatic send_beats(input int n, input int gap_before, input int gap_len, input bit full);
        int acc = 0;
        for (int b = 0; b < n; b++) begin
            if (b == gap_before) begin
                in_valid_i = 1'b0;
                ori_i = $urandom();
                can_i = $urandom();
                repeat (gap_len) step();
            end
            in_valid_i = 1'b1;
            ori_i = blk_o[b];
            can_i = blk_c[b];
            acc += beat_sad(blk_o[b], blk_c[b]);
            if (full && b == ROWS - 1) model_block(acc, cyc + 3);
            step();
        end
        in_valid_i = 1'b0;
        ori_i = $urandom();
        can_i = $urandom();
    endtask

    task automatic send_block(input int gap_before, input int gap_len);
        send_beats(ROWS, gap_before, gap_len, 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (sad_q.size() != 0 || best_q.size() != 0); i++) step();
        repeat (3) step();
        vecs++;
        if (sad_q.size() != 0 || best_q.size() != 0) begin
            errs++;
            $display("FAIL drain: pending sad=%0d best=%0d, required 0/0", sad_q.size(), best_q.size());
            sad_q.delete();
            best_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        vecs += 6;
        if (sad_valid_o !== 1'b0)  begin errs++; $display("FAIL %s sad_valid: got %0b want 0", tag, sad_valid_o); end
        if (sad_out_o !== '0)      begin errs++; $display("FAIL %s sad_out: got %0d want 0", tag, sad_out_o); end
        if (cand_idx_o !== '0)     begin errs++; $display("FAIL %s cand_idx: got %0d want 0", tag, cand_idx_o); end
        if (best_valid_o !== 1'b0) begin errs++; $display("FAIL %s best_valid: got %0b want 0", tag, best_valid_o); end
        if (best_sad_o !== '0)     begin errs++; $display("FAIL %s best_sad: got %0d want 0", tag, best_sad_o); end
        if (best_idx_o !== '0)     begin errs++; $display("FAIL %s best_idx: got %0d want 0", tag, best_idx_o); end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sad_valid_o) begin
                if (sad_q.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL sad_unexpected: pulse at cycle %0d sad=%0d, required none", cyc, sad_out_o);
                end else begin
                    es = sad_q.pop_front();
                    vecs += 3;
                    if (sad_out_o !== SAD_W'(es.sad)) begin errs++; $display("FAIL sad_out: got %0d want %0d", sad_out_o, es.sad); end
                    if (cand_idx_o !== IDX_W'(es.idx)) begin errs++; $display("FAIL cand_idx: got %0d want %0d", cand_idx_o, es.idx); end
                    if (cyc != es.cycle) begin errs++; $display("FAIL sad_timing: cycle %0d want %0d", cyc, es.cycle); end
                end
            end
            if (best_valid_o) begin
                if (best_q.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL best_unexpected: pulse at cycle %0d best=%0d, required none", cyc, best_sad_o);
                end else begin
                    eb = best_q.pop_front();
                    vecs += 3;
                    if (best_sad_o !== SAD_W'(eb.sad)) begin errs++; $display("FAIL best_sad: got %0d want %0d", best_sad_o, eb.sad); end
                    if (best_idx_o !== IDX_W'(eb.idx)) begin errs++; $display("FAIL best_idx: got %0d want %0d", best_idx_o, eb.idx); end
                    if (cyc != eb.cycle) begin errs++; $display("FAIL best_timing: cycle %0d want %0d", cyc, eb.cycle); end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        in_valid_i = 1'b1;
        ori_i = 32'hFFFF_FFFF;
        repeat (3) step();
        check_all_zero("reset");
        in_valid_i = 1'b0;
        rst = 1'b0;
        model_reset();
        step();
    endtask

    task automatic test_basic();
        set_uniform(10, 3);
        send_block(-1, 0);
        wait_drain();
    endtask

    task automatic test_orderings();
        set_uniform(3, 10);
        blk_o[1] = 32'h0A03_0A03;
        blk_c[1] = 32'h030A_030A;
        send_block(-1, 0);
        wait_drain();
        set_uniform(255, 0);
        send_block(-1, 0);
        wait_drain();
    endtask

    task automatic test_gap();
        set_uniform(10, 3);
        send_block(2, 2);
        wait_drain();
    endtask

    task automatic test_back_to_back_window();
        int sads[8] = '{112, 40, 40, 200, 5, 6, 7, 8};
        foreach (sads[i]) begin
            set_block_sad(sads[i]);
            send_block(-1, 0);
        end
        wait_drain();
        repeat (5) step();
        vecs += 3;
        if (best_sad_o !== 12'd5) begin errs++; $display("FAIL best_sad_hold: got %0d want 5", best_sad_o); end
        if (best_idx_o !== 2'd0)  begin errs++; $display("FAIL best_idx_hold: got %0d want 0", best_idx_o); end
        if (sad_out_o !== 12'd8)  begin errs++; $display("FAIL sad_out_hold: got %0d want 8", sad_out_o); end
    endtask

    task automatic test_clear();
        set_block_sad(60);
        send_block(-1, 0);
        wait_drain();
        set_uniform(10, 3);
        send_beats(2, -1, 0, 1'b0);
        clear_i = 1'b1;
        in_valid_i = 1'b1;
        ori_i = 32'h1234_5678;
        step();
        clear_i = 1'b0;
        in_valid_i = 1'b0;
        check_all_zero("clear");
        model_reset();
        blk_o = '{32'h0000_000A, 32'h0000_000A, 32'h0000_000A, 32'h0000_000A};
        blk_c = '{32'h0000_0003, 32'h0000_0003, 32'h0000_0003, 32'h0000_0003};
        send_block(-1, 0);
        wait_drain();
    endtask

    task automatic test_rst_mid_window();
        set_block_sad(3);
        send_block(-1, 0);
        set_block_sad(4);
        send_block(-1, 0);
        wait_drain();
        set_block_sad(50);
        send_beats(2, -1, 0, 1'b0);
        rst = 1'b1;
        in_valid_i = 1'b1;
        step();
        check_all_zero("rst_mid");
        rst = 1'b0;
        in_valid_i = 1'b0;
        model_reset();
        for (int i = 0; i < CANDS; i++) begin
            set_block_sad(9);
            send_block(-1, 0);
        end
        wait_drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_orderings();
        test_gap();
        test_back_to_back_window();
        test_clear();
        test_rst_mid_window();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
